// File: rtl/audio_pkg.sv
// Shared constants and FSM state encodings for the audio clip sequencer.
package audio_pkg;

  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned CLIP_DEPTH = 65536;
  localparam int unsigned NUM_CLIPS  = 2;
  localparam int unsigned CLIP_W     = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_REC_WAIT  = 3'd1;
  localparam state_t ST_REC_WRITE = 3'd2;
  localparam state_t ST_PLAY_READ = 3'd3;
  localparam state_t ST_PLAY_LOAD = 3'd4;
  localparam state_t ST_PLAY_WAIT = 3'd5;

endpackage

// File: rtl/clip_sequencer_if.sv
// Control/status bundle between the button/codec side and the clip sequencer.
interface clip_sequencer_if #(
  parameter int unsigned ADDR_W = audio_pkg::ADDR_W,
  parameter int unsigned CLIP_W = audio_pkg::CLIP_W
);

  logic              play_req;
  logic              record_req;
  logic [CLIP_W-1:0] play_clip;
  logic [CLIP_W-1:0] record_clip;
  logic              des_done;
  logic              ser_done;
  logic              des_enable;
  logic              ser_enable;
  logic              mem_en;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic              ser_load;
  logic              playing;
  logic              recording;
  logic [CLIP_W-1:0] active_clip;

  modport master (
    output play_req, record_req, play_clip, record_clip, des_done, ser_done,
    input  des_enable, ser_enable, mem_en, mem_wen, mem_addr, ser_load,
           playing, recording, active_clip
  );

  modport slave (
    input  play_req, record_req, play_clip, record_clip, des_done, ser_done,
    output des_enable, ser_enable, mem_en, mem_wen, mem_addr, ser_load,
           playing, recording, active_clip
  );

endinterface

// File: rtl/clip_len_table.sv
// Per-clip recorded length registers: written when a recording ends, read by clip index.
module clip_len_table #(
  parameter int unsigned NUM_CLIPS = 2,
  parameter int unsigned CLIP_W    = 1,
  parameter int unsigned LEN_W     = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CLIP_W-1:0] wr_clip,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [CLIP_W-1:0] rd_clip,
  output logic [LEN_W-1:0]  rd_len
);

  logic [LEN_W-1:0] len_q [NUM_CLIPS];

  // Length storage, cleared on reset, one entry updated per recording.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_CLIPS); i++) begin
        len_q[i] <= '0;
      end
    end else if (wr_en) begin
      len_q[wr_clip] <= wr_len;
    end
  end

  assign rd_len = len_q[rd_clip];

endmodule

// File: rtl/clip_sequencer.sv
// Record/playback sequencer: moves samples between the codec (de)serializer and BRAM clip regions.
module clip_sequencer #(
  parameter int unsigned ADDR_W     = audio_pkg::ADDR_W,
  parameter int unsigned CLIP_DEPTH = audio_pkg::CLIP_DEPTH,
  parameter int unsigned NUM_CLIPS  = audio_pkg::NUM_CLIPS
) (
  input  logic            clock,
  input  logic            reset,
  clip_sequencer_if.slave bus
);

  import audio_pkg::state_t;
  import audio_pkg::ST_IDLE;
  import audio_pkg::ST_REC_WAIT;
  import audio_pkg::ST_REC_WRITE;
  import audio_pkg::ST_PLAY_READ;
  import audio_pkg::ST_PLAY_LOAD;
  import audio_pkg::ST_PLAY_WAIT;

  localparam int unsigned       CLIP_W = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH  = ADDR_W'(CLIP_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] offset_q, offset_d, offset_inc;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CLIP_W-1:0] active_q, active_d;
  logic              pend_q, pend_d;
  logic              run_q;
  logic              mem_en_q, mem_en_d;
  logic              mem_wen_q, mem_wen_d;
  logic              ser_load_q, ser_load_d;
  logic              des_en_q, des_en_d;
  logic              ser_en_q, ser_en_d;
  logic              playing_q, playing_d;
  logic              recording_q, recording_d;

  logic              len_we;
  logic [ADDR_W-1:0] len_wr_val;
  logic [CLIP_W-1:0] len_rd_clip;
  logic [ADDR_W-1:0] len_rd;
  logic              play_ok, rec_ok;

  function automatic logic [ADDR_W-1:0] clip_base(input logic [CLIP_W-1:0] clip);
    return ADDR_W'(clip) * DEPTH;
  endfunction

  // Requests are ignored on the first edge after reset release.
  assign play_ok    = run_q & bus.play_req;
  assign rec_ok     = run_q & bus.record_req;
  assign offset_inc = offset_q + ADDR_W'(1);

  clip_len_table #(
    .NUM_CLIPS (NUM_CLIPS),
    .CLIP_W    (CLIP_W),
    .LEN_W     (ADDR_W)
  ) u_len_table (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (len_we),
    .wr_clip (active_q),
    .wr_len  (len_wr_val),
    .rd_clip (len_rd_clip),
    .rd_len  (len_rd)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      offset_q    <= '0;
      mem_addr_q  <= '0;
      active_q    <= '0;
      pend_q      <= 1'b0;
      run_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      ser_load_q  <= 1'b0;
      des_en_q    <= 1'b0;
      ser_en_q    <= 1'b0;
      playing_q   <= 1'b0;
      recording_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      mem_addr_q  <= mem_addr_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      run_q       <= 1'b1;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      ser_load_q  <= ser_load_d;
      des_en_q    <= des_en_d;
      ser_en_q    <= ser_en_d;
      playing_q   <= playing_d;
      recording_q <= recording_d;
    end
  end

  // Next-state and next-output decode; outputs describe the state being entered.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    mem_addr_d  = mem_addr_q;
    active_d    = active_q;
    pend_d      = pend_q;
    mem_en_d    = 1'b0;
    mem_wen_d   = 1'b0;
    ser_load_d  = 1'b0;
    des_en_d    = 1'b0;
    ser_en_d    = 1'b0;
    playing_d   = 1'b0;
    recording_d = 1'b0;
    len_we      = 1'b0;
    len_wr_val  = (offset_q > DEPTH) ? DEPTH : offset_q;
    len_rd_clip = (state_q == ST_IDLE) ? bus.play_clip : active_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rec_ok) begin
          state_d     = ST_REC_WAIT;
          offset_d    = '0;
          pend_d      = 1'b0;
          active_d    = bus.record_clip;
          recording_d = 1'b1;
          des_en_d    = 1'b1;
        end else if (play_ok && (len_rd != '0)) begin
          state_d    = ST_PLAY_READ;
          offset_d   = '0;
          active_d   = bus.play_clip;
          mem_addr_d = clip_base(bus.play_clip);
          mem_en_d   = 1'b1;
          playing_d  = 1'b1;
        end
      end

      ST_REC_WAIT: begin
        if (rec_ok) begin
          state_d = ST_IDLE;
          len_we  = 1'b1;
          pend_d  = 1'b0;
        end else begin
          recording_d = 1'b1;
          des_en_d    = 1'b1;
          if (bus.des_done || pend_q) begin
            state_d    = ST_REC_WRITE;
            pend_d     = 1'b0;
            mem_addr_d = clip_base(active_q) + offset_q;
            offset_d   = offset_inc;
            mem_en_d   = 1'b1;
            mem_wen_d  = 1'b1;
          end
        end
      end

      ST_REC_WRITE: begin
        if (rec_ok || (offset_q >= DEPTH)) begin
          state_d = ST_IDLE;
          len_we  = 1'b1;
          pend_d  = 1'b0;
        end else begin
          state_d     = ST_REC_WAIT;
          recording_d = 1'b1;
          des_en_d    = 1'b1;
          if (bus.des_done) begin
            pend_d = 1'b1;
          end
        end
      end

      ST_PLAY_READ: begin
        if (play_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_PLAY_LOAD;
          ser_load_d = 1'b1;
          playing_d  = 1'b1;
        end
      end

      ST_PLAY_LOAD: begin
        if (play_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_PLAY_WAIT;
          ser_en_d  = 1'b1;
          playing_d = 1'b1;
        end
      end

      ST_PLAY_WAIT: begin
        if (play_ok) begin
          state_d = ST_IDLE;
        end else if (bus.ser_done) begin
          offset_d = offset_inc;
          if (offset_inc == len_rd) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_PLAY_READ;
            mem_addr_d = clip_base(active_q) + offset_inc;
            mem_en_d   = 1'b1;
            playing_d  = 1'b1;
          end
        end else begin
          ser_en_d  = 1'b1;
          playing_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_wen     = mem_wen_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.ser_load    = ser_load_q;
  assign bus.des_enable  = des_en_q;
  assign bus.ser_enable  = ser_en_q;
  assign bus.playing     = playing_q;
  assign bus.recording   = recording_q;
  assign bus.active_clip = active_q;

endmodule
